// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter slice.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents: word alignment constants, requester index constants,
// response field widths and a misalignment helper.
package dmem_pkg;

    // The memory holds whole words, so the low address bits select a byte.
    localparam int WORD_BYTES = 4;
    localparam int ALIGN_BITS = $clog2(WORD_BYTES);

    // Requester indices, used as the grant/owner encoding.
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    // Response field widths (owner index, error flag).
    localparam int RSP_OWNER_W = 1;
    localparam int RSP_ERR_W   = 1;

    // A word access is misaligned when any byte-select bit is set.
    function automatic logic is_misaligned(input logic [ALIGN_BITS-1:0] lo);
        return |lo;
    endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Latency: count reflects an inc on the following cycle.
// Backpressure: none; every inc is absorbed (or ignored once saturated).
//
// Ports: clk, reset (sync, active-high), inc (count one event),
//        count (current saturating value).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word data memory.
// Latency: grant and memory drive same cycle; response registered, 1 cycle later.
// Backpressure: rN_ready drops for the loser under contention; loser wins next cycle.
//
// Ports: requester 0 (core) and requester 1 (debug/DMA) each present
//        valid/we/addr/wd and see ready plus a one-cycle response strobe
//        with read data and a misalignment error flag. The mem_* ports drive
//        the memory (combinational read data back on mem_rd). grant_cnt0/1
//        are saturating per-requester acceptance counters.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              r0_valid,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wd,
    output logic              r0_ready,
    output logic              r0_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_rd,
    output logic              r0_rsp_err,

    input  logic              r1_valid,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wd,
    output logic              r1_ready,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r1_rsp_rd,
    output logic              r1_rsp_err,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,

    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    // ------------------------------------------------------------------
    // Arbitration state and response pipeline registers
    // ------------------------------------------------------------------
    logic                   r_last_grant;
    logic                   r_rsp_vld;
    logic [RSP_OWNER_W-1:0] r_rsp_owner;
    logic [RSP_ERR_W-1:0]   r_rsp_err;
    logic [DATA_W-1:0]      r_rsp_rd;

    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   w_any;
    logic                   w_win;
    logic                   w_win_we;
    logic [ADDR_W-1:0]      w_win_addr;
    logic [DATA_W-1:0]      w_win_wd;
    logic                   w_mis;

    // Round-robin: under contention the requester that did not win last
    // time goes first. Nothing is granted while reset is held.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (r0_valid && r1_valid) begin
                if (r_last_grant == REQ_CORE) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b1;
                end
            end else begin
                w_gnt0 = r0_valid;
                w_gnt1 = r1_valid;
            end
        end
    end

    assign w_any = w_gnt0 | w_gnt1;
    assign w_win = w_gnt1 ? REQ_DBG : REQ_CORE;

    assign r0_ready = w_gnt0;
    assign r1_ready = w_gnt1;

    // Winner's request, forced to zero when idle so the memory port is quiet.
    always_comb begin
        w_win_we   = 1'b0;
        w_win_addr = '0;
        w_win_wd   = '0;
        if (w_gnt0) begin
            w_win_we   = r0_we;
            w_win_addr = r0_addr;
            w_win_wd   = r0_wd;
        end else if (w_gnt1) begin
            w_win_we   = r1_we;
            w_win_addr = r1_addr;
            w_win_wd   = r1_wd;
        end
    end

    assign w_mis = is_misaligned(w_win_addr[ALIGN_BITS-1:0]);

    // Misaligned writes are still accepted but must not touch memory.
    assign mem_we   = w_any & w_win_we & ~w_mis;
    assign mem_addr = w_win_addr;
    assign mem_wd   = w_win_wd;

    // ------------------------------------------------------------------
    // Response capture at the edge that ends the grant cycle. Read data is
    // sampled from the combinational memory output in the same cycle as the
    // address, so the response is exactly one cycle behind the acceptance.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= REQ_DBG;
            r_rsp_vld    <= 1'b0;
            r_rsp_owner  <= '0;
            r_rsp_err    <= '0;
            r_rsp_rd     <= '0;
        end else begin
            r_rsp_vld <= w_any;
            if (w_any) begin
                r_last_grant <= w_win;
                r_rsp_owner  <= w_win;
                r_rsp_err    <= w_mis;
                r_rsp_rd     <= (!w_win_we && !w_mis) ? mem_rd : '0;
            end else begin
                // Keep data/err at zero between responses.
                r_rsp_err    <= '0;
                r_rsp_rd     <= '0;
            end
        end
    end

    // Steer the single registered response to its owner only.
    assign r0_rsp_valid = r_rsp_vld && (r_rsp_owner == REQ_CORE);
    assign r1_rsp_valid = r_rsp_vld && (r_rsp_owner == REQ_DBG);
    assign r0_rsp_rd    = r0_rsp_valid ? r_rsp_rd : '0;
    assign r1_rsp_rd    = r1_rsp_valid ? r_rsp_rd : '0;
    assign r0_rsp_err   = r0_rsp_valid & r_rsp_err[0];
    assign r1_rsp_err   = r1_rsp_valid & r_rsp_err[0];

    // ------------------------------------------------------------------
    // Grant counters; misaligned acceptances count like any other.
    // ------------------------------------------------------------------
    sat_counter #(.CNT_W(CNT_W)) u_cnt0 (
        .clk   (clk),
        .reset (reset),
        .inc   (w_gnt0),
        .count (grant_cnt0)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
        .clk   (clk),
        .reset (reset),
        .inc   (w_gnt1),
        .count (grant_cnt1)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural word memory.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              r0_valid = 1'b0, r0_we = 1'b0;
    logic [ADDR_W-1:0] r0_addr = '0;
    logic [DATA_W-1:0] r0_wd = '0;
    logic              r0_ready, r0_rsp_valid, r0_rsp_err;
    logic [DATA_W-1:0] r0_rsp_rd;
    logic              r1_valid = 1'b0, r1_we = 1'b0;
    logic [ADDR_W-1:0] r1_addr = '0;
    logic [DATA_W-1:0] r1_wd = '0;
    logic              r1_ready, r1_rsp_valid, r1_rsp_err;
    logic [DATA_W-1:0] r1_rsp_rd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;
    logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wd(r0_wd),
        .r0_ready(r0_ready), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rd(r0_rsp_rd),
        .r0_rsp_err(r0_rsp_err),
        .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wd(r1_wd),
        .r1_ready(r1_ready), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rd(r1_rsp_rd),
        .r1_rsp_err(r1_rsp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    // Behavioural memory: combinational read, write at posedge.
    logic [DATA_W-1:0] mem [16];
    assign mem_rd = mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wd;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          cyc;
        bit          owner;
        logic [31:0] rd;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_mem [16];
    bit          m_last = 1'b1;
    int          m_cnt0 = 0;
    int          m_cnt1 = 0;
    int          cyc = 0;
    bit          p_acc = 1'b0;
    bit          p_owner = 1'b0;
    bit          p_we = 1'b0;
    logic [5:0]  p_addr = '0;
    logic [31:0] p_wd = '0;

    // Mid-cycle check of responses, grants, memory drive and counters.
    always @(negedge clk) begin : monitor
        exp_t        h;
        bit          hit, e0, e1, g0, g1, any, wwe, mis;
        logic [5:0]  wad;
        logic [31:0] wwd;
        hit = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        if (hit) h = exp_q.pop_front();
        e0 = hit && (h.owner == 1'b0);
        e1 = hit && (h.owner == 1'b1);
        chk("rsp_vld0", r0_rsp_valid, e0);
        chk("rsp_vld1", r1_rsp_valid, e1);
        chk("rsp_rd0",  r0_rsp_rd,  e0 ? h.rd : 32'h0);
        chk("rsp_rd1",  r1_rsp_rd,  e1 ? h.rd : 32'h0);
        chk("rsp_err0", r0_rsp_err, e0 ? h.err : 1'b0);
        chk("rsp_err1", r1_rsp_err, e1 ? h.err : 1'b0);

        g0 = 1'b0; g1 = 1'b0;
        if (!reset) begin
            if (r0_valid && r1_valid) begin
                g0 = (m_last == 1'b1);
                g1 = (m_last == 1'b0);
            end else begin
                g0 = r0_valid;
                g1 = r1_valid;
            end
        end
        any = g0 | g1;
        wwe = g0 ? r0_we : (g1 ? r1_we : 1'b0);
        wad = g0 ? r0_addr : (g1 ? r1_addr : 6'd0);
        wwd = g0 ? r0_wd : (g1 ? r1_wd : 32'd0);
        mis = (wad[1:0] != 2'b00);
        chk("ready0", r0_ready, g0);
        chk("ready1", r1_ready, g1);
        chk("mem_we", mem_we, any && wwe && !mis);
        chk("mem_addr", mem_addr, wad);
        chk("mem_wd", mem_wd, wwd);
        chk("cnt0", grant_cnt0, m_cnt0);
        chk("cnt1", grant_cnt1, m_cnt1);

        p_acc = any; p_owner = g1; p_we = wwe; p_addr = wad; p_wd = wwd;
    end

    // Model state advance at the active edge (reset sampled here, as in the DUT).
    always @(posedge clk) begin : model
        exp_t e;
        if (reset) begin
            exp_q.delete();
            m_last = 1'b1;
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else if (p_acc) begin
            m_last  = p_owner;
            e.cyc   = cyc + 1;
            e.owner = p_owner;
            e.err   = (p_addr[1:0] != 2'b00);
            e.rd    = (!p_we && !e.err) ? exp_mem[p_addr[5:2]] : 32'h0;
            exp_q.push_back(e);
            if (p_we && !e.err) exp_mem[p_addr[5:2]] = p_wd;
            if (p_owner) begin
                if (m_cnt1 != CNT_MAX) m_cnt1++;
            end else begin
                if (m_cnt0 != CNT_MAX) m_cnt0++;
            end
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input bit v0, input bit we0, input logic [5:0] a0, input logic [31:0] d0,
                         input bit v1, input bit we1, input logic [5:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wd = d0;
        r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wd = d1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'hA500_0000 + 32'(i * 17);
            exp_mem[i] = 32'hA500_0000 + 32'(i * 17);
        end
        mem[2]     = 32'h0000_0003;
        exp_mem[2] = 32'h0000_0003;

        // Reset held for a few cycles, then release.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // Single read of preloaded word 2.
        drive(1'b1, 1'b0, 6'd8, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0);
        idle(2);

        // Contention: both reading continuously for four cycles.
        do_reset();
        repeat (4) drive(1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd4, 32'd0);
        idle(1);
        chk("rr_cnt0", grant_cnt0, 3'd2);
        chk("rr_cnt1", grant_cnt1, 3'd2);
        idle(1);

        // Write from r1, then read back from r0.
        drive(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 6'd60, 32'h1234_5678);
        drive(1'b1, 1'b0, 6'd60, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0);
        idle(2);

        // Misaligned write, then aligned and misaligned readback.
        drive(1'b1, 1'b1, 6'd6, 32'hDEAD_BEEF, 1'b0, 1'b0, 6'd0, 32'd0);
        drive(1'b1, 1'b0, 6'd4, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0);
        drive(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd6, 32'd0);
        idle(2);
        chk("mis_word1", mem[1], 32'hA500_0011);

        // Saturation of a 3-bit counter.
        do_reset();
        repeat (9) drive(1'b1, 1'b0, 6'd12, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0);
        idle(1);
        chk("sat_cnt0", grant_cnt0, 3'd7);
        chk("sat_cnt1", grant_cnt1, 3'd0);
        idle(1);

        // Reset lands on the edge that ends an r1 acceptance.
        drive(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd8, 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        r1_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midop_rsp1", r1_rsp_valid, 1'b0);
        chk("midop_cnt0", grant_cnt0, 3'd0);
        reset = 1'b0;
        r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 6'd0;
        r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 6'd4;
        @(negedge clk);
        #1;
        chk("midop_first_r0", r0_ready, 1'b1);
        drive(1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd4, 32'd0);
        idle(2);

        // Random traffic including writes and misaligned addresses.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb, rc, rd0, rd1;
            ra = $urandom; rb = $urandom; rc = $urandom;
            rd0 = $urandom; rd1 = $urandom;
            drive(ra[0], ra[1], rb[5:0], rd0, ra[2], ra[3], rc[5:0], rd1);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
